// File: rtl/card_pkg.sv
// Shared card definitions for the hand store: field widths, legal value ranges,
// FSM state type and a card legality helper.
package card_pkg;

    localparam int COLOR_W  = 2;
    localparam int NUMBER_W = 3;
    localparam int CARD_W   = COLOR_W + NUMBER_W;

    localparam logic [CARD_W-1:0]   CARD_EMPTY = '0;
    localparam logic [COLOR_W-1:0]  COLOR_MIN  = 2'd1;
    localparam logic [COLOR_W-1:0]  COLOR_MAX  = 2'd3;
    localparam logic [NUMBER_W-1:0] NUMBER_MIN = 3'd1;
    localparam logic [NUMBER_W-1:0] NUMBER_MAX = 3'd5;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } hand_state_t;

    // Compared as int so the check stays valid if the field ranges ever change.
    function automatic logic card_legal(input logic [COLOR_W-1:0]  color,
                                        input logic [NUMBER_W-1:0] number);
        return (int'(color)  >= int'(COLOR_MIN))  && (int'(color)  <= int'(COLOR_MAX)) &&
               (int'(number) >= int'(NUMBER_MIN)) && (int'(number) <= int'(NUMBER_MAX));
    endfunction

endpackage

// File: rtl/card_match.sv
// Play legality: a card matches the pile top on colour or number; an empty
// pile (top colour 0) accepts anything.
module card_match
    import card_pkg::*;
(
    input  logic [CARD_W-1:0]   card,
    input  logic [COLOR_W-1:0]  top_color,
    input  logic [NUMBER_W-1:0] top_number,
    output logic                match
);

    assign match = (top_color == '0) ||
                   (card[CARD_W-1:NUMBER_W] == top_color) ||
                   (card[NUMBER_W-1:0] == top_number);

endmodule

// File: rtl/card_hand_buffer.sv
// Per-player hand store with draw, play and slot compaction.
// Define HAND_MATCH_CHECK_EN to reject plays that do not match the pile top.
module card_hand_buffer
    import card_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                draw_en,
    input  logic [1:0]          draw_color,
    input  logic [2:0]          draw_number,
    input  logic                play_en,
    input  logic [3:0]          play_idx,
    input  logic [1:0]          top_color,
    input  logic [2:0]          top_number,
    input  logic [3:0]          peek_idx,
    output logic [4:0]          peek_card,
    output logic [CNT_W-1:0]    count,
    output logic                full,
    output logic                empty,
    output logic                busy,
    output logic                play_ok,
    output logic                play_err,
    output logic                draw_err,
    output logic [4:0]          played_card
);

    localparam int IDX_W = $clog2(DEPTH);

    hand_state_t        state, state_nxt;
    logic [CARD_W-1:0]  slots [DEPTH];
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   ptr_inc;
    logic [IDX_W-1:0]   play_sel;
    logic [CARD_W-1:0]  sel_card;
    logic               match_ok;
    logic               play_in_range;
    logic               play_is_last;
    logic               shift_last;
    logic               do_draw;
    logic               do_accept;
    logic               shift_done;
    logic               draw_err_nxt;
    logic               play_err_nxt;

    assign play_sel      = play_idx[IDX_W-1:0];
    assign sel_card      = slots[play_sel];
    assign ptr_inc       = ptr + IDX_W'(1);
    assign play_in_range = 32'(play_idx) < 32'(count);
    assign play_is_last  = 32'(play_idx) == 32'(count) - 1;
    assign shift_last    = 32'(ptr) + 1 == 32'(count) - 1;

`ifdef HAND_MATCH_CHECK_EN
    card_match u_match (
        .card       (sel_card),
        .top_color  (top_color),
        .top_number (top_number),
        .match      (match_ok)
    );
`else
    logic unused_top;
    assign unused_top = ^{top_color, top_number};
    assign match_ok   = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        do_draw      = 1'b0;
        do_accept    = 1'b0;
        shift_done   = 1'b0;
        draw_err_nxt = 1'b0;
        play_err_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (play_en) begin
                    // Play wins over a simultaneous draw; the draw is reported as dropped.
                    draw_err_nxt = draw_en;
                    if (play_in_range && match_ok) begin
                        do_accept = 1'b1;
                        if (!play_is_last) state_nxt = SHIFT;
                    end else begin
                        play_err_nxt = 1'b1;
                    end
                end else if (draw_en) begin
                    if (card_legal(draw_color, draw_number) && !full) do_draw = 1'b1;
                    else                                              draw_err_nxt = 1'b1;
                end
            end
            SHIFT: begin
                draw_err_nxt = draw_en;
                play_err_nxt = play_en;
                if (shift_last) begin
                    shift_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) slots[i] <= CARD_EMPTY;
            count       <= '0;
            ptr         <= '0;
            played_card <= CARD_EMPTY;
            play_ok     <= 1'b0;
            play_err    <= 1'b0;
            draw_err    <= 1'b0;
        end else begin
            play_ok  <= do_accept;
            play_err <= play_err_nxt;
            draw_err <= draw_err_nxt;
            if (do_draw) begin
                slots[count[IDX_W-1:0]] <= {draw_color, draw_number};
                count                   <= count + CNT_W'(1);
            end
            if (do_accept) begin
                played_card     <= sel_card;
                slots[play_sel] <= CARD_EMPTY;
                ptr             <= play_sel;
                if (play_is_last) count <= count - CNT_W'(1);
            end
            if (state == SHIFT) begin
                slots[ptr] <= slots[ptr_inc];
                ptr        <= ptr_inc;
                if (shift_done) begin
                    slots[ptr_inc] <= CARD_EMPTY;
                    count          <= count - CNT_W'(1);
                end
            end
        end
    end

    assign busy      = (state == SHIFT);
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign peek_card = (32'(peek_idx) < 32'(count)) ? slots[peek_idx[IDX_W-1:0]] : CARD_EMPTY;

endmodule

// File: tb/tb_card_hand_buffer.sv
// Bench for card_hand_buffer: directed scenarios followed by random traffic,
// all checked against a queue-based model of the hand.
module tb_card_hand_buffer;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       draw_en = 1'b0;
    logic [1:0] draw_color = '0;
    logic [2:0] draw_number = '0;
    logic       play_en = 1'b0;
    logic [3:0] play_idx = '0;
    logic [1:0] top_color = '0;
    logic [2:0] top_number = '0;
    logic [3:0] peek_idx = '0;
    logic [4:0] peek_card;
    logic [3:0] count;
    logic       full, empty, busy, play_ok, play_err, draw_err;
    logic [4:0] played_card;

    card_hand_buffer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .draw_en     (draw_en),
        .draw_color  (draw_color),
        .draw_number (draw_number),
        .play_en     (play_en),
        .play_idx    (play_idx),
        .top_color   (top_color),
        .top_number  (top_number),
        .peek_idx    (peek_idx),
        .peek_card   (peek_card),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .busy        (busy),
        .play_ok     (play_ok),
        .play_err    (play_err),
        .draw_err    (draw_err),
        .played_card (played_card)
    );

    always #50 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    logic [4:0] hand [$];
    int         busy_left = 0;
    logic [4:0] m_played = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_match(input logic [4:0] c, input logic [1:0] tc, input logic [2:0] tn);
`ifdef HAND_MATCH_CHECK_EN
        return (tc == 0) || (c[4:3] == tc) || (c[2:0] == tn);
`else
        return 1'b1;
`endif
    endfunction

    function automatic bit m_legal(input logic [1:0] c, input logic [2:0] n);
        return (c >= 1) && (n >= 1) && (n <= 5);
    endfunction

    task automatic check_state(input bit e_pok, input bit e_perr, input bit e_derr);
        int vis;
        vis = hand.size() + ((busy_left > 0) ? 1 : 0);
        chk("play_ok", play_ok, e_pok);
        chk("play_err", play_err, e_perr);
        chk("draw_err", draw_err, e_derr);
        chk("count", count, vis);
        chk("busy", busy, busy_left > 0);
        chk("full", full, vis == DEPTH);
        chk("empty", empty, vis == 0);
        chk("played_card", played_card, m_played);
        if (busy_left == 0) begin
            for (int i = 0; i < 16; i++) begin
                peek_idx = 4'(i);
                #1;
                chk($sformatf("peek%0d", i), peek_card, (i < hand.size()) ? hand[i] : 5'b0);
            end
        end
    endtask

    task automatic cycle(input bit de, input logic [1:0] dc, input logic [2:0] dn,
                         input bit pe, input logic [3:0] pi,
                         input logic [1:0] tc, input logic [2:0] tn);
        bit e_pok, e_perr, e_derr;
        e_pok = 0; e_perr = 0; e_derr = 0;
        if (busy_left > 0) begin
            e_derr = de;
            e_perr = pe;
            busy_left--;
        end else if (pe) begin
            e_derr = de;
            if (int'(pi) < hand.size() && m_match(hand[pi], tc, tn)) begin
                e_pok     = 1;
                m_played  = hand[pi];
                busy_left = hand.size() - 1 - int'(pi);
                hand.delete(int'(pi));
            end else begin
                e_perr = 1;
            end
        end else if (de) begin
            if (m_legal(dc, dn) && hand.size() < DEPTH) hand.push_back({dc, dn});
            else                                       e_derr = 1;
        end
        draw_en = de; draw_color = dc; draw_number = dn;
        play_en = pe; play_idx = pi; top_color = tc; top_number = tn;
        @(posedge clk);
        #1;
        draw_en = 0;
        play_en = 0;
        check_state(e_pok, e_perr, e_derr);
    endtask

    task automatic draw(input logic [1:0] c, input logic [2:0] n);
        cycle(1, c, n, 0, 0, 0, 0);
    endtask

    task automatic idle_cycle();
        cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic apply_reset();
        rst = 0;
        #1;
        hand.delete();
        busy_left = 0;
        m_played  = '0;
        peek_idx  = 0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_peek", peek_card, 0);
        chk("rst_empty", empty, 1);
        chk("rst_played", played_card, 0);
        chk("rst_pulses", {play_ok, play_err, draw_err}, 0);
        @(posedge clk);
        #1;
        chk("rst_hold_pulses", {play_ok, play_err, draw_err}, 0);
        chk("rst_hold_count", count, 0);
        rst = 1;
        #1;
    endtask

    initial begin
        apply_reset();

        // Basic draws and peek.
        draw(1, 3); draw(2, 5); draw(3, 1);
        peek_idx = 1;
        #1;
        chk("peek_idx1", peek_card, 5'b10101);
        chk("count3", count, 3);
        chk("not_empty", empty, 0);

        // Play from the middle, compaction over two cycles.
        draw(2, 2);
        cycle(0, 0, 0, 1, 1, 2, 4);
        chk("mid_play_ok", play_ok, 1);
        chk("mid_played", played_card, 5'b10101);
        chk("mid_busy", busy, 1);
        idle_cycle();
        chk("mid_busy2", busy, 1);
        idle_cycle();
        chk("mid_done", busy, 0);
        peek_idx = 0; #1; chk("mid_slot0", peek_card, 5'b01011);
        peek_idx = 1; #1; chk("mid_slot1", peek_card, 5'b11001);
        peek_idx = 2; #1; chk("mid_slot2", peek_card, 5'b10010);
        chk("mid_count", count, 3);

        // Match rule: {1,3} against top {3,4}.
        cycle(0, 0, 0, 1, 0, 3, 4);
`ifdef HAND_MATCH_CHECK_EN
        chk("nomatch_err", play_err, 1);
`else
        chk("nomatch_ok", play_ok, 1);
`endif
        while (busy_left > 0) idle_cycle();

        // Play and draw together: play wins, draw reported.
        cycle(1, 1, 1, 1, 4'(hand.size() - 1), 0, 0);
        chk("both_play_ok", play_ok, 1);
        chk("both_draw_err", draw_err, 1);

        // Out-of-range play.
        apply_reset();
        draw(1, 1); draw(2, 2); draw(3, 3);
        cycle(0, 0, 0, 1, 5, 0, 0);
        chk("range_err", play_err, 1);

        // Illegal cards.
        draw(0, 2);
        chk("illegal_color", draw_err, 1);
        draw(1, 6);
        chk("illegal_number", draw_err, 1);
        draw(2, 0);

        // Fill and overflow.
        while (hand.size() < DEPTH) draw(2'(1 + hand.size() % 3), 3'(1 + hand.size() % 5));
        draw(1, 1);
        chk("ovf_err", draw_err, 1);
        chk("ovf_full", full, 1);
        chk("ovf_count", count, DEPTH);

        // Requests during SHIFT, then reset mid-shift.
        cycle(0, 0, 0, 1, 0, 0, 0);
        cycle(1, 1, 1, 0, 0, 0, 0);
        chk("busy_draw_err", draw_err, 1);
        cycle(0, 0, 0, 1, 0, 0, 0);
        chk("busy_play_err", play_err, 1);
        chk("still_busy", busy, 1);
        apply_reset();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            cycle($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  $urandom_range(0, 2) == 0, 4'($urandom_range(0, 9)),
                  2'($urandom_range(0, 3)), 3'($urandom_range(0, 5)));
        end
        while (busy_left > 0) idle_cycle();
        apply_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
